// File: rtl/i2s_tx.sv
// I2S transmitter: one-frame holding register feeding a 2*WIDTH-bit frame register,
// with SCLK/LRCK/SDATA all derived from clk through a fixed divider.
module i2s_tx #(
  parameter int WIDTH    = 16,
  parameter int SCLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] L_IN,
  input  logic [WIDTH-1:0] R_IN,
  input  logic             VALID,
  output logic             READY,
  output logic             SCLK,
  output logic             LRCK,
  output logic             SDATA,
  output logic             UNDERRUN
);

  localparam int FW = 2 * WIDTH;
  localparam int BW = $clog2(FW);
  localparam int DW = $clog2(SCLK_DIV);

  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [BW-1:0] bit_nxt;
  logic [BW-1:0] idx;
  logic [FW-1:0] hold;
  logic [FW-1:0] frame;
  logic          hold_full;
  logic          tick;
  logic          fall;
  logic          accept;
  logic          data_bit;

  always_comb begin
    tick     = (div_cnt == DW'(SCLK_DIV - 1));
    fall     = tick & SCLK;
    bit_nxt  = (bit_cnt == BW'(FW - 1)) ? '0 : bit_cnt + BW'(1);
    // Slot s carries frame bit 2*WIDTH-s; slot 0 carries the old frame's LSB.
    idx      = BW'(FW - 1) - bit_nxt + BW'(1);
    data_bit = (bit_nxt == '0) ? frame[0] : frame[idx];
    accept   = VALID & ~hold_full;
  end

  assign READY = ~hold_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      bit_cnt   <= BW'(FW - 1);
      frame     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      SCLK      <= 1'b0;
      LRCK      <= 1'b0;
      SDATA     <= 1'b0;
      UNDERRUN  <= 1'b0;
    end else begin
      UNDERRUN <= 1'b0;
      if (tick) begin
        div_cnt <= '0;
        SCLK    <= ~SCLK;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
      if (fall) begin
        bit_cnt <= bit_nxt;
        LRCK    <= (bit_nxt >= BW'(WIDTH));
        SDATA   <= data_bit;
        if (bit_nxt == '0) begin
          if (hold_full) begin
            frame     <= hold;
            hold_full <= 1'b0;
          end else begin
            frame    <= '0;
            UNDERRUN <= 1'b1;
          end
        end
      end
      // Only taken while empty, so it never overlaps a load that drains the holding register.
      if (accept) begin
        hold      <= {L_IN, R_IN};
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx (WIDTH=16, SCLK_DIV=2): reset, bit timing, frame order,
// underrun pulses, full-scale data and mid-frame reset.
module tb_i2s_tx;

  logic        clk;
  logic        rst_n;
  logic [15:0] L_IN;
  logic [15:0] R_IN;
  logic        VALID;
  logic        READY;
  logic        SCLK;
  logic        LRCK;
  logic        SDATA;
  logic        UNDERRUN;

  int checks   = 0;
  int failures = 0;
  logic [31:0] pend[$];

  i2s_tx #(.WIDTH(16), .SCLK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .L_IN(L_IN), .R_IN(R_IN), .VALID(VALID),
    .READY(READY), .SCLK(SCLK), .LRCK(LRCK), .SDATA(SDATA), .UNDERRUN(UNDERRUN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk3(input string tag, input int slot, input logic [2:0] obs, input logic [2:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s slot=%0d observed={sclk,lrck,sdata}=%b expected=%b", tag, slot, obs, expv);
    end
  endtask

  task automatic drive();
    if (pend.size() != 0) begin
      VALID = 1'b1;
      {L_IN, R_IN} = pend[0];
    end else begin
      VALID = 1'b0;
    end
  endtask

  // One clk; the sender advances its queue when the handshake completes.
  task automatic step();
    logic hs;
    hs = VALID & READY;
    @(posedge clk);
    @(negedge clk);
    if (hs) void'(pend.pop_front());
    drive();
  endtask

  task automatic push(input logic [31:0] f);
    pend.push_back(f);
    drive();
  endtask

  // Starts just after a slot-0 fall event of frame cur; ends just after the next one.
  task automatic send_check(input logic [31:0] cur, input logic prev_lsb,
                            input logic exp_under, input logic ready_mid);
    logic [31:0] t;
    logic        sd;
    for (int s = 0; s < 32; s++) begin
      step();
      if (s == 0) chk1("underrun_width", UNDERRUN, 1'b0);
      step();
      t  = cur >> (32 - s);
      sd = (s == 0) ? prev_lsb : t[0];
      chk3("slot_bits", s, {SCLK, LRCK, SDATA}, {1'b1, (s >= 16), sd});
      if (s == 16) chk1("ready_mid_frame", READY, ready_mid);
      step();
      step();
      chk1("underrun_at_fall", UNDERRUN, (s == 31) ? exp_under : 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    VALID = 1'b0;
    L_IN  = '0;
    R_IN  = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk1("rst_sclk", SCLK, 1'b0);
    chk1("rst_lrck", LRCK, 1'b0);
    chk1("rst_sdata", SDATA, 1'b0);
    chk1("rst_underrun", UNDERRUN, 1'b0);
    chk1("rst_ready", READY, 1'b1);
    rst_n = 1'b1;

    step();
    chk1("edge1_sclk", SCLK, 1'b0);
    push(32'hA5F0_0F0F);
    step();
    chk1("edge2_sclk", SCLK, 1'b1);
    chk1("edge2_ready", READY, 1'b0);
    step();
    chk1("edge3_sclk", SCLK, 1'b1);
    step();
    chk1("edge4_sclk", SCLK, 1'b0);
    chk1("edge4_underrun", UNDERRUN, 1'b0);
    chk1("edge4_ready", READY, 1'b1);
    chk1("edge4_sdata", SDATA, 1'b0);

    send_check(32'hA5F0_0F0F, 1'b0, 1'b1, 1'b1);
    send_check(32'h0, 1'b1, 1'b1, 1'b1);

    push(32'h1234_ABCD);
    push(32'hFEDC_0001);
    push(32'h8000_7FFF);
    send_check(32'h0, 1'b0, 1'b0, 1'b0);
    chk1("f1_load_ready", READY, 1'b1);
    send_check(32'h1234_ABCD, 1'b0, 1'b0, 1'b0);
    chk1("f2_load_ready", READY, 1'b1);
    send_check(32'hFEDC_0001, 1'b1, 1'b0, 1'b0);
    chk1("f3_load_ready", READY, 1'b1);
    chk1("f3_load_valid_idle", VALID, 1'b0);

    push(32'hCAFE_BEEF);
    push(32'h5555_AAAA);
    send_check(32'h8000_7FFF, 1'b1, 1'b0, 1'b0);

    repeat (42) step();
    chk3("pre_reset_slot10", 10, {SCLK, LRCK, SDATA}, 3'b101);
    chk1("pre_reset_ready", READY, 1'b0);

    #2 rst_n = 1'b0;
    #1;
    chk1("async_rst_sclk", SCLK, 1'b0);
    chk1("async_rst_sdata", SDATA, 1'b0);
    chk1("async_rst_lrck", LRCK, 1'b0);
    chk1("async_rst_ready", READY, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    step();
    step();
    chk1("rerun_edge2_sclk", SCLK, 1'b1);
    step();
    step();
    chk1("rerun_edge4_sclk", SCLK, 1'b0);
    chk1("rerun_edge4_underrun", UNDERRUN, 1'b1);
    chk1("rerun_edge4_sdata", SDATA, 1'b0);
    step();
    chk1("rerun_edge5_underrun", UNDERRUN, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Serializes the stereo PCM samples that leave the audio effect chain (e.g. distortion OUT) into an I2S stream for an external DAC.
- Accepts parallel left/right words through a valid/ready handshake.
- Buffers one stereo frame.
- Generates bit clock (SCLK), word select (LRCK) and serial data (SDATA) from the single system clock.

Parameters:
WIDTH, 16, sample width in bits; one I2S slot per channel is WIDTH bits, so a frame is 2*WIDTH bits.
SCLK_DIV, 4, clk cycles per SCLK half-period; SCLK period = 2*SCLK_DIV clk; legal values >= 2.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst_n  input  1  asynchronous active-low reset.
L_IN  input  WIDTH  left sample, two's complement.
R_IN  input  WIDTH  right sample, two's complement.
VALID  input  1  L_IN/R_IN hold a frame to send.
READY  output  1  holding register empty; a frame is accepted when VALID & READY at a clk edge.
SCLK  output  1  I2S bit clock, registered.
LRCK  output  1  I2S word select, registered; 0 = left, 1 = right.
SDATA  output  1  I2S serial data, registered, MSB first.
UNDERRUN  output  1  one-clk pulse when a frame slot starts with no buffered sample.

Behaviour:
- Reset (async, rst_n=0):
  - SCLK=0, LRCK=0, SDATA=0, UNDERRUN=0.
  - Holding register cleared; hold_full=0, so READY=1.
  - div_cnt=0; bit_cnt=2*WIDTH-1; shift register = 0.
- READY = !hold_full (combinational from the register).
- Divider:
  - div_cnt increments every clk.
  - At div_cnt==SCLK_DIV-1, div_cnt<=0 and SCLK toggles.
  - A 1->0 toggle is a "fall event"; all LRCK/SDATA/bit_cnt updates happen only in the fall-event clk, so they change together with the SCLK falling edge. The DAC samples on SCLK rise.
- Slot counter:
  - At each fall event, bit_cnt <= (bit_cnt==2*WIDTH-1) ? 0 : bit_cnt+1. The new value s is the slot being entered.
  - The first fall event after reset (clk edge 2*SCLK_DIV) enters slot 0.
- LRCK: at a fall event entering slot s, LRCK <= (s >= WIDTH).
- SDATA (standard I2S, one-bit delay after LRCK change):
  - Entering slot 0: SDATA <= shift register LSB (the previous frame's R LSB).
  - In the same clk, a frame load occurs.
  - Entering slot s, 1..2*WIDTH-1: SDATA <= bit (2*WIDTH-s) of the loaded frame {L,R}. L MSB goes out in slot 1; R MSB goes out in slot WIDTH+1.
- Frame load (fall event entering slot 0):
  - If hold_full: shift register <= holding {L,R}; hold_full <= 0.
  - Else: shift register <= 0 (mute) and UNDERRUN=1 for exactly that clk.
- Accept:
  - VALID & READY at a clk edge: holding <= {L_IN,R_IN}; hold_full <= 1.
  - No bypass. A frame accepted in the same clk as a load that finds hold empty is not used by that load: the load mutes and UNDERRUN pulses, and the frame is sent in the next frame.
  - A load and an accept cannot collide on a full holding register, because READY=0 while full.
- Latency: an accepted frame is transmitted starting at the next slot-0 fall event. Its L MSB appears on SDATA one SCLK period later (slot 1).
- Data is passed verbatim, with no arithmetic, sign handling or truncation.
- Reset mid-frame: all state returns to reset values immediately; any buffered frame is discarded. After rst_n release, timing restarts exactly as from power-on.

Test Plan:
- Reset, WIDTH=16, SCLK_DIV=2, hold rst_n low 5 clk -> SCLK=LRCK=SDATA=UNDERRUN=0, READY=1. After release: SCLK rises at clk edge 2, falls at edge 4 (slot 0), and has period 4 clk thereafter.
- Push L=16'hA5F0, R=16'h0F0F one clk after reset release; sample SDATA/LRCK at each SCLK rise -> READY drops for one frame until load, then returns to 1.
  - Slot 0 SDATA=0; slots 1-16 = A5F0 MSB first.
  - LRCK=0 for slots 0-15, 1 for slots 16-31.
  - Slots 17-31 = 0F0F bits 15..1; next frame slot 0 = 1.
- No VALID ever -> UNDERRUN pulses once per 128 clk (2*16*4), at every slot-0 fall event; SDATA stays 0.
- Hold VALID continuously with frames F1, F2, F3 (sender advances on handshake) -> F1 accepted at once and F2 accepted right after F1 loads. F3 waits with READY=0 until F2 loads. Frames are sent in order with no UNDERRUN after the first frame.
- Full-scale frames L=16'h8000, R=16'h7FFF -> slot 1 = 1, then slots 2-16 = 0; slot 17 = 0, then slots 18-31 and next slot 0 all 1.
- Assert rst_n=0 during slot 10 with a frame buffered -> outputs 0 asynchronously, READY=1 and buffered frame lost. After release, first fall event at clk edge 4 gives UNDERRUN=1.
